// File: rtl/draw_arbiter.sv
// draw_arbiter: shares the single VGA adapter write port between NREQ drawing
// engines. It picks a requester by round-robin (gated to frame ticks), sends it
// a one-cycle go pulse, and forwards its pixel stream until its busy drops.
//
// Optional feature macro: DRAW_ARB_PRIORITY_EN
//   defined   -> engine 0 wins whenever it requests; ptr is left untouched when
//                engine 0 is served, so the others rotate among themselves.
//   undefined -> pure round-robin.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   frame                  one-cycle frame tick (new grants only on it if FRAME_GATE)
//   req[NREQ]              level request per engine
//   busy[NREQ]             draw_state of each engine
//   in_x/in_y/in_colour    packed per-engine pixel fields, engine i at [i*W +: W]
//   in_plot[NREQ]          per-engine plot strobe
//   go[NREQ]               one-hot, one-cycle start pulse to the granted engine
//   grant[NREQ]            one-hot, high for the whole ownership
//   vga_x/y/colour/plot    forwarded pixel stream to the adapter (latency 1)
//   arb_busy               high whenever the arbiter is not idle
module draw_arbiter #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 10,
    parameter int unsigned CW         = 3,
    parameter int unsigned FRAME_GATE = 1,
    parameter int unsigned START_TO   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      busy,
    input  logic [NREQ*XW-1:0]   in_x,
    input  logic [NREQ*YW-1:0]   in_y,
    input  logic [NREQ*CW-1:0]   in_colour,
    input  logic [NREQ-1:0]      in_plot,
    output logic [NREQ-1:0]      go,
    output logic [NREQ-1:0]      grant,
    output logic [XW-1:0]        vga_x,
    output logic [YW-1:0]        vga_y,
    output logic [CW-1:0]        vga_colour,
    output logic                 vga_plot,
    output logic                 arb_busy
);

    localparam int unsigned IW = (NREQ > 2) ? 2 : 1;
    localparam int unsigned TW = $clog2(START_TO + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        DRAW,
        RELEASE
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [TW-1:0]   to_cnt;

    logic [IW-1:0]   pick_c;
    logic            pick_vld_c;
    logic [XW-1:0]   sel_x_c;
    logic [YW-1:0]   sel_y_c;
    logic [CW-1:0]   sel_colour_c;
    logic            sel_plot_c;
    logic            sel_busy_c;
    logic            grant_ok_c;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Requester selection: first requester after ptr, wrapping modulo NREQ.
    always_comb begin
        pick_c     = '0;
        pick_vld_c = 1'b0;
`ifdef DRAW_ARB_PRIORITY_EN
        if (req[0]) begin
            pick_vld_c = 1'b1;
            pick_c     = '0;
        end
`endif
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr) + k) % NREQ;
            if (!pick_vld_c && req[IW'(idx)]) begin
                pick_vld_c = 1'b1;
                pick_c     = IW'(idx);
            end
        end
    end

    // Winner's stream fields, muxed out of the packed inputs.
    always_comb begin
        sel_x_c      = in_x[32'(winner)*XW +: XW];
        sel_y_c      = in_y[32'(winner)*YW +: YW];
        sel_colour_c = in_colour[32'(winner)*CW +: CW];
        sel_plot_c   = in_plot[winner];
        sel_busy_c   = busy[winner];
    end

    assign grant_ok_c = pick_vld_c && ((FRAME_GATE == 0) || frame);

    // Ownership FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= IW'(NREQ - 1);
            winner     <= '0;
            to_cnt     <= '0;
            go         <= '0;
            grant      <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            arb_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok_c) begin
                        winner   <= pick_c;
                        grant    <= onehot(pick_c);
                        go       <= onehot(pick_c);
                        arb_busy <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    go     <= '0;
                    to_cnt <= '0;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    vga_x      <= sel_x_c;
                    vga_y      <= sel_y_c;
                    vga_colour <= sel_colour_c;
                    vga_plot   <= sel_plot_c;
                    if (sel_busy_c) begin
                        state <= DRAW;
                    end else if (to_cnt == TW'(START_TO - 1)) begin
                        // lost start: engine never acknowledged go
                        state <= RELEASE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DRAW: begin
                    // the pixel presented alongside busy falling is still forwarded
                    vga_x      <= sel_x_c;
                    vga_y      <= sel_y_c;
                    vga_colour <= sel_colour_c;
                    vga_plot   <= sel_plot_c;
                    if (!sel_busy_c) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    grant    <= '0;
                    vga_plot <= 1'b0;
                    arb_busy <= 1'b0;
`ifdef DRAW_ARB_PRIORITY_EN
                    if (winner != '0) begin
                        ptr <= winner;
                    end
`else
                    ptr <= winner;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
